// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

    localparam int unsigned XLEN              = 32;
    localparam int unsigned INSTR_BYTES       = 4;
    localparam int unsigned MEM_WORDS_DEFAULT = 64;

    // One fetched instruction together with the PC it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Small in-order skid FIFO holding fetched {pc, instr} entries.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   push, entry  write entry (accepted when not full, or full with a pop)
//   pop          remove the head entry (ignored when empty)
//   flush        discard all entries; wins over push and pop
//   full, empty  occupancy flags
//   head         current head entry (zero after reset)
module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t entry,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t       mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO can still accept a push when the head leaves the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

    // Entry storage; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= entry;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: owns the PC, reads the asynchronous instruction ROM and
// queues {pc, instr} for decode over a valid/ready handshake. Handles
// branch redirects (flush) and a sticky fault on illegal PCs.
// Ports:
//   clk, reset                     clock and asynchronous active-high reset
//   imem_addr / imem_instr         ROM byte address (= pc) and read data
//   redirect_valid / redirect_pc   taken branch: flush and load new PC
//   out_valid / out_ready          decode handshake for the head entry
//   out_pc / out_instr             head entry payload
//   fetch_fault                    sticky: fetch stopped on an illegal PC
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter int unsigned DEPTH     = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        fetch_fault
);

    localparam logic [31:0] PC_LIMIT = 32'(MEM_WORDS * INSTR_BYTES);
    localparam logic [31:0] PC_STEP  = 32'(INSTR_BYTES);

    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic         fault_q;
    logic         fault_d;
    logic         pc_legal;
    logic         pop;
    logic         fetch;
    logic         fifo_full;
    logic         fifo_empty;
    fetch_entry_t push_entry;
    fetch_entry_t head;

    assign pc_legal   = (pc_q[1:0] == 2'b00) && (pc_q < PC_LIMIT);
    // Decode never sees an entry during a redirect, so nothing pops then.
    assign out_valid  = !fifo_empty && !redirect_valid;
    assign pop        = out_valid && out_ready;
    assign fetch      = !redirect_valid && !fault_q && pc_legal && (!fifo_full || pop);
    assign push_entry = '{pc: pc_q, instr: imem_instr};

    assign imem_addr   = pc_q;
    assign out_pc      = head.pc;
    assign out_instr   = head.instr;
    assign fetch_fault = fault_q;

    // PC and fault next-state: redirect first, then fault, then advance.
    always_comb begin
        pc_d    = pc_q;
        fault_d = fault_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            fault_d = 1'b0;
        end else if (!fault_q && !pc_legal) begin
            fault_d = 1'b1;
        end else if (fetch) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // PC and fault state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fetch),
        .entry (push_entry),
        .pop   (pop),
        .flush (redirect_valid),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed testbench for ifetch_unit with a behavioural ROM whose word at
// index i holds 32'hC0DE_0000 + i.
module tb_ifetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        fetch_fault;

    int checks   = 0;
    int failures = 0;

    ifetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .fetch_fault    (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: word index in the low bits.
    assign imem_instr = 32'hC0DE_0000 + {24'h0, imem_addr[9:2]};

    function automatic logic [31:0] rom(input logic [31:0] addr);
        return 32'hC0DE_0000 + {24'h0, addr[9:2]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and let comb logic settle.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;

        // Reset state
        step();
        check("rst_addr",   imem_addr,          32'h0);
        check("rst_valid",  32'(out_valid),     32'h0);
        check("rst_fault",  32'(fetch_fault),   32'h0);
        check("rst_pc",     out_pc,             32'h0);
        check("rst_instr",  out_instr,          32'h0);

        // Release; one edge later the PC-0 entry is at the head
        @(negedge clk);
        reset = 1'b0;
        step();
        check("first_valid", 32'(out_valid), 32'h1);
        check("first_pc",    out_pc,         32'h0);
        check("first_instr", out_instr,      rom(32'h0));

        // Backpressure: two entries fill the FIFO, PC stalls at 8
        step();
        step();
        step();
        check("bp_addr",  imem_addr,      32'h8);
        check("bp_pc",    out_pc,         32'h0);
        check("bp_valid", 32'(out_valid), 32'h1);

        // One-cycle ready: pop and fetch together
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("pop1_pc",    out_pc,    32'h4);
        check("pop1_instr", out_instr, rom(32'h4));
        check("pop1_addr",  imem_addr, 32'hC);

        // Redirect while full
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        #1;
        check("redir_valid0", 32'(out_valid), 32'h0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("redir_addr",  imem_addr,      32'h40);
        check("redir_empty", 32'(out_valid), 32'h0);
        step();
        check("redir_valid", 32'(out_valid), 32'h1);
        check("redir_pc",    out_pc,         32'h40);
        check("redir_instr", out_instr,      rom(32'h40));

        // Streaming from 0 with out_ready held high: no bubbles
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("str_empty", 32'(out_valid), 32'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("str_valid", 32'(out_valid), 32'h1);
            check("str_pc",    out_pc,         32'(4 * k));
            check("str_instr", out_instr,      rom(32'(4 * k)));
        end

        // Range fault at 0x100
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hF8;
        @(negedge clk);
        redirect_valid = 1'b0;
        step();
        check("rng_pc0",    out_pc,            32'hF8);
        check("rng_instr0", out_instr,         rom(32'hF8));
        check("rng_flt0",   32'(fetch_fault),  32'h0);
        step();
        check("rng_pc1",    out_pc,            32'hFC);
        check("rng_addr",   imem_addr,         32'h100);
        check("rng_flt1",   32'(fetch_fault),  32'h0);
        step();
        check("rng_flt2",   32'(fetch_fault),  32'h1);
        check("rng_valid2", 32'(out_valid),    32'h0);
        step();
        check("rng_valid3", 32'(out_valid),    32'h0);
        check("rng_hold",   imem_addr,         32'h100);
        check("rng_sticky", 32'(fetch_fault),  32'h1);

        // Redirect to 0 clears the fault and resumes
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        #1;
        check("clr_pre", 32'(fetch_fault), 32'h1);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("clr_flt", 32'(fetch_fault), 32'h0);
        step();
        check("clr_valid", 32'(out_valid), 32'h1);
        check("clr_pc",    out_pc,         32'h0);

        // Misaligned redirect
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("mis_addr", imem_addr,         32'h2);
        check("mis_flt0", 32'(fetch_fault),  32'h0);
        step();
        check("mis_flt1",  32'(fetch_fault), 32'h1);
        check("mis_valid", 32'(out_valid),   32'h0);
        check("mis_hold",  imem_addr,        32'h2);

        // Async reset while faulted
        #2;
        reset = 1'b1;
        #1;
        check("ar1_flt",   32'(fetch_fault), 32'h0);
        check("ar1_addr",  imem_addr,        32'h0);
        check("ar1_valid", 32'(out_valid),   32'h0);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b0;

        // Fill the FIFO, then reset mid-stream
        step();
        step();
        check("fill_valid", 32'(out_valid), 32'h1);
        check("fill_addr",  imem_addr,      32'h8);
        #2;
        reset = 1'b1;
        #1;
        check("ar2_valid", 32'(out_valid), 32'h0);
        check("ar2_addr",  imem_addr,      32'h0);
        check("ar2_pc",    out_pc,         32'h0);
        check("ar2_instr", out_instr,      32'h0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check("post_valid", 32'(out_valid), 32'h1);
        check("post_pc",    out_pc,         32'h0);
        check("post_addr",  imem_addr,      32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Fetch stage directly upstream of the asynchronous 64-word instruction ROM (`imem`).
- Owns the program counter and drives the ROM address.
- Captures the returned instruction with its PC into a small skid FIFO and presents {pc, instr} to decode over a valid/ready handshake.
- Handles branch redirects (flush) and raises a sticky fetch fault on misaligned or out-of-range PCs.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_WORDS, 64, instruction ROM depth in words; legal PCs are 0 .. MEM_WORDS*4-4.
- DEPTH, 2, FIFO entries (power of two, >=2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_addr  out  32  byte address to ROM; equals pc_q.
- imem_instr  in  32  ROM read data, combinational from imem_addr.
- redirect_valid  in  1  branch/jump taken; loads redirect_pc and flushes.
- redirect_pc  in  32  new fetch PC.
- out_valid  out  1  head FIFO entry available to decode.
- out_ready  in  1  decode accepts head entry.
- out_pc  out  32  PC of head entry.
- out_instr  out  32  instruction of head entry.
- fetch_fault  out  1  sticky: fetch stopped on illegal PC.

Behaviour:
- Reset (async, while high):
  - pc_q=RESET_PC, FIFO count=0, fault_q=0.
  - Outputs: imem_addr=RESET_PC, out_valid=0, fetch_fault=0.
  - out_pc and out_instr read 0.
- imem_addr = pc_q at all times; imem_instr is sampled in the same cycle.
- pc_legal = (pc_q[1:0]==0) && (pc_q < MEM_WORDS*4).
- pop = out_valid && out_ready.
- fetch = !redirect_valid && !fault_q && pc_legal && (count<DEPTH || pop).
  - A full FIFO with a simultaneous pop still fetches, so throughput is one instruction per cycle.
- On fetch: push {pc_q, imem_instr}, pc_q <= pc_q+4 (32-bit wrap, no carry out).
- Stall: FIFO full and no pop -> pc_q holds, imem_addr held, no push.
- Redirect has highest priority:
  - Next edge: count<=0 (flush), pc_q<=redirect_pc, fault_q<=0.
  - No push that cycle.
  - out_valid is forced 0 combinationally while redirect_valid=1, so no pop occurs in a redirect cycle.
- Fault: when !redirect_valid && !fault_q && !pc_legal:
  - fault_q<=1 on next edge; nothing pushed; pc_q holds.
  - fetch_fault=fault_q.
  - Entries already in the FIFO still drain normally.
  - Only reset or redirect clears the fault.
- Latency:
  - Instruction at PC p, fetched in cycle n, appears at out_* in cycle n+1 if the FIFO was empty.
  - First out_valid is the first cycle after reset deassertion + 1 edge.
- FIFO ordering: strict in order. out_* reflect the head entry and are stable while out_valid=1 && out_ready=0.
- Simultaneous events:
  - push+pop on an empty FIFO is impossible (out_valid=0).
  - push+pop on a full FIFO keeps count constant.
  - redirect+fault in the same cycle: redirect wins.
- Reset mid-operation: immediate clear regardless of handshake state; no partial entry survives.

Decomposition:
- Package ifetch_pkg:
  - typedef fetch_entry_t (struct: logic [31:0] pc, logic [31:0] instr).
  - Constants INSTR_BYTES=4 and the MEM_WORDS default.
- Sub-module fetch_fifo:
  - Parameterized DEPTH, element type fetch_entry_t.
  - Ports: push, pop, flush, full, empty, head, plus clk/reset.
  - The top level holds the PC, legality check, fault, and redirect logic.

Test Plan:
- Reset: reset=1 with RESET_PC=0 -> imem_addr=0, out_valid=0, fetch_fault=0. After release, one edge -> out_valid=1, out_pc=0, out_instr=mem[0].
- Streaming: out_ready=1 constant -> out_pc sequence 0,4,8,12 on consecutive cycles, each out_instr=mem[pc/4], no bubbles.
- Backpressure:
  - out_ready=0 from start -> after 2 pushes imem_addr stays 8 and out_pc stays 0.
  - Raise out_ready for one cycle -> out_pc becomes 4 and imem_addr advances to 12 the same edge.
- Redirect while full: FIFO holds {0,4}, redirect_valid=1, redirect_pc=0x40 -> out_valid=0 that cycle. Next cycle imem_addr=0x40, count=0. Following cycle out_pc=0x40.
- Range fault: redirect to 0xF8, out_ready=1 -> out_pc 0xF8, 0xFC delivered. PC 0x100 sets fetch_fault=1 one edge later; no further out_valid. Redirect to 0x0 clears the fault and resumes at 0.
- Misalign and mid-reset: redirect_pc=0x2 -> fetch_fault=1 next edge, no push. Then async reset pulse mid-stream -> out_valid=0 and fetch_fault=0 immediately, imem_addr=0.
